// File: rtl/floo_look_ahead_route_sched.sv
// Round-robin scheduler that shares one look-ahead route unit among all input
// ports and keeps each port's next-hop direction until that port consumes it.
module floo_look_ahead_route_sched #(
    parameter int unsigned NumPorts      = 5,
    parameter int unsigned IdWidth       = 6,
    parameter int unsigned RouteDirWidth = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumPorts-1:0]               req_valid_i,
    output logic [NumPorts-1:0]               req_ready_o,
    input  logic [NumPorts*IdWidth-1:0]       req_dst_id_i,
    input  logic [NumPorts*RouteDirWidth-1:0] req_dir_i,
    output logic [IdWidth-1:0]                lar_dst_id_o,
    output logic [RouteDirWidth-1:0]          lar_dir_o,
    input  logic [RouteDirWidth-1:0]          lar_result_i,
    output logic [NumPorts-1:0]               res_valid_o,
    output logic [NumPorts*RouteDirWidth-1:0] res_dir_o,
    input  logic [NumPorts-1:0]               res_ready_i,
    output logic                              busy_o
);

    localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [PtrWidth-1:0] LastPort = PtrWidth'(NumPorts - 1);

    logic [IdWidth-1:0]       dst_id      [NumPorts];
    logic [RouteDirWidth-1:0] cur_dir     [NumPorts];
    logic [RouteDirWidth-1:0] res_dir_reg [NumPorts];
    logic [NumPorts-1:0]      res_valid_reg;
    logic [NumPorts-1:0]      eligible;
    logic [NumPorts-1:0]      grant_onehot;
    logic [PtrWidth-1:0]      ptr_reg;
    logic [PtrWidth-1:0]      ptr_next;
    logic [PtrWidth-1:0]      grant_idx;
    logic                     grant_valid;

    // A slot that is being consumed this cycle may be refilled in the same cycle.
    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            assign dst_id[gi]   = req_dst_id_i[gi*IdWidth +: IdWidth];
            assign cur_dir[gi]  = req_dir_i[gi*RouteDirWidth +: RouteDirWidth];
            assign eligible[gi] = req_valid_i[gi] & (~res_valid_reg[gi] | res_ready_i[gi]);
            assign res_dir_o[gi*RouteDirWidth +: RouteDirWidth] = res_dir_reg[gi];
        end
    endgenerate

    always_comb begin : arbiter
        int unsigned cand;
        logic [PtrWidth-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned off = 0; off < NumPorts; off++) begin
            cand = 32'(ptr_reg) + off;
            if (cand >= NumPorts) begin
                cand = cand - NumPorts;
            end
            cand_idx = cand[PtrWidth-1:0];
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        // Nothing is accepted while reset is held.
        if (!rst_ni) begin
            grant_valid = 1'b0;
            grant_idx   = '0;
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_idx == LastPort) ? '0 : grant_idx + PtrWidth'(1);
        end
    end

    assign req_ready_o  = grant_onehot;
    assign lar_dst_id_o = grant_valid ? dst_id[grant_idx]  : '0;
    assign lar_dir_o    = grant_valid ? cur_dir[grant_idx] : '0;
    assign res_valid_o  = res_valid_reg;
    assign busy_o       = (|req_valid_i) | (|res_valid_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg       <= '0;
            res_valid_reg <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                res_dir_reg[p] <= '0;
            end
        end else begin
            ptr_reg <= ptr_next;
            for (int p = 0; p < NumPorts; p++) begin
                if (grant_onehot[p]) begin
                    res_valid_reg[p] <= 1'b1;
                    res_dir_reg[p]   <= lar_result_i;
                end else if (res_ready_i[p]) begin
                    res_valid_reg[p] <= 1'b0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));
    a_grant_slot_free : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((req_ready_o & res_valid_reg & ~res_ready_i) == '0));
`endif

endmodule

// File: tb/tb_floo_look_ahead_route_sched.sv
// Directed and randomized checks of the route scheduler against a queue-free
// behavioural model of slots, round-robin pointer and stored directions.
module tb_floo_look_ahead_route_sched;

    localparam int NP = 5;
    localparam int IW = 6;
    localparam int DW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP*IW-1:0]  req_dst;
    logic [NP*DW-1:0]  req_dir;
    logic [IW-1:0]     lar_dst;
    logic [DW-1:0]     lar_dir;
    logic [DW-1:0]     lar_result;
    logic [NP-1:0]     res_valid;
    logic [NP*DW-1:0]  res_dir;
    logic [NP-1:0]     res_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    bit          m_val [NP];
    logic [DW-1:0] m_dir [NP];

    always #5 clk = ~clk;

    floo_look_ahead_route_sched #(
        .NumPorts(NP), .IdWidth(IW), .RouteDirWidth(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_dst_id_i(req_dst), .req_dir_i(req_dir),
        .lar_dst_id_o(lar_dst), .lar_dir_o(lar_dir), .lar_result_i(lar_result),
        .res_valid_o(res_valid), .res_dir_o(res_dir), .res_ready_i(res_ready),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int p = 0; p < NP; p++) begin
            m_val[p] = 1'b0;
            m_dir[p] = '0;
        end
    endtask

    // First port at or after the pointer that requests and has a free slot.
    function automatic int model_grant();
        for (int k = 0; k < NP; k++) begin
            int p = (m_ptr + k) % NP;
            if (req_valid[p] && (!m_val[p] || res_ready[p])) return p;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] exp_valid();
        logic [NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p] = m_val[p];
        return r;
    endfunction

    function automatic logic [NP*DW-1:0] exp_dir();
        logic [NP*DW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*DW +: DW] = m_dir[p];
        return r;
    endfunction

    task automatic set_req(input int p, input logic [IW-1:0] dst, input logic [DW-1:0] dir);
        req_valid[p]        = 1'b1;
        req_dst[p*IW +: IW] = dst;
        req_dir[p*DW +: DW] = dir;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(output int g);
        logic [31:0] e_rdy;
        logic [31:0] e_dst;
        logic [31:0] e_dir;
        bit          e_busy;
        #1;
        g     = model_grant();
        e_rdy = 0;
        e_dst = 0;
        e_dir = 0;
        if (g >= 0) begin
            e_rdy = 32'd1 << g;
            e_dst = 32'(req_dst[g*IW +: IW]);
            e_dir = 32'(req_dir[g*DW +: DW]);
        end
        e_busy = (req_valid != '0);
        for (int p = 0; p < NP; p++) if (m_val[p]) e_busy = 1'b1;
        chk("req_ready", 32'(req_ready), e_rdy);
        chk("lar_dst", 32'(lar_dst), e_dst);
        chk("lar_dir", 32'(lar_dir), e_dir);
        chk("busy", 32'(busy), 32'(e_busy));
        if (g >= 0)
            $display("grant port %0d dst %0h dir %0d result %0d", g, e_dst, e_dir, lar_result);
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (p == g) begin
                m_val[p] = 1'b1;
                m_dir[p] = lar_result;
            end else if (res_ready[p]) begin
                m_val[p] = 1'b0;
            end
        end
        if (g >= 0) m_ptr = (g == NP - 1) ? 0 : g + 1;
        #1;
        chk("res_valid", 32'(res_valid), 32'(exp_valid()));
        chk("res_dir", 32'(res_dir), 32'(exp_dir()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = '1;
        #1;
        model_reset();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_dir", 32'(res_dir), 32'd0);
        chk("rst_lar_dst", 32'(lar_dst), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        res_ready = '0;
    endtask

    initial begin
        int g;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_dst    = '0;
        req_dir    = '0;
        res_ready  = '0;
        lar_result = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request from port 2
        set_req(2, 6'h09, 3'd1);
        lar_result = 3'd0;
        cycle(g);
        req_valid = '0;
        cycle(g);

        // All ports requesting continuously from reset
        do_reset();
        res_ready = '1;
        for (int p = 0; p < NP; p++) set_req(p, IW'(p + 8), DW'(p));
        for (int n = 0; n < 6; n++) begin
            lar_result = DW'($urandom_range(0, 7));
            cycle(g);
        end
        req_valid = '0;

        // Back-pressure on port 1
        res_ready = 5'b11101;
        set_req(1, 6'h21, 3'd2);
        lar_result = 3'd5;
        cycle(g);
        set_req(1, 6'h22, 3'd3);
        for (int n = 0; n < 10; n++) begin
            lar_result = DW'($urandom_range(0, 7));
            cycle(g);
        end
        res_ready[1] = 1'b1;
        lar_result   = 3'd6;
        cycle(g);
        req_valid = '0;
        res_ready = '0;
        cycle(g);

        // Wrap from pointer 4
        do_reset();
        res_ready = '1;
        set_req(3, 6'h03, 3'd0);
        cycle(g);
        req_valid = '0;
        set_req(0, 6'h10, 3'd1);
        set_req(4, 6'h14, 3'd2);
        lar_result = 3'd3;
        cycle(g);
        if (g >= 0) req_valid[g] = 1'b0;
        lar_result = 3'd4;
        cycle(g);
        if (g >= 0) req_valid[g] = 1'b0;
        set_req(0, 6'h20, 3'd1);
        set_req(1, 6'h21, 3'd1);
        cycle(g);
        req_valid = '0;

        // Asynchronous reset with several stored results
        do_reset();
        set_req(1, 6'h01, 3'd1);
        set_req(2, 6'h02, 3'd2);
        set_req(4, 6'h04, 3'd4);
        for (int n = 0; n < 3; n++) begin
            lar_result = DW'(n + 1);
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        chk("pre_reset_valid", 32'(res_valid), 32'h16);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_dir", 32'(res_dir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(3, 6'h33, 3'd3);
        set_req(2, 6'h32, 3'd2);
        cycle(g);
        req_valid = '0;

        // Dropped request on port 3
        do_reset();
        set_req(0, 6'h05, 3'd1);
        set_req(3, 6'h06, 3'd2);
        cycle(g);
        req_valid = '0;
        for (int n = 0; n < 4; n++) cycle(g);
        chk("dropped_port3", 32'(res_valid[3]), 32'd0);

        // Randomized traffic with holding requesters
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (req_valid[p]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[p] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    set_req(p, IW'($urandom_range(0, 63)), DW'($urandom_range(0, 7)));
                end
            end
            res_ready  = NP'($urandom_range(0, 31));
            lar_result = DW'($urandom_range(0, 7));
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
